// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch port
// (read-only) and the MEM-stage load/store port of the 16-bit pipeline.
// Each granted access holds the memory bus for WAIT_CYCLES cycles and is then
// followed by a one-cycle response state in which the served port's valid
// pulses.
//
// Ports:
//   CLK, RST_n                  clock, synchronous active-low reset
//   if_req/if_addr              fetch request, held until if_valid
//   if_rdata/if_valid/stall_if  fetched instruction, completion pulse, stall
//   d_rd/d_wr/d_addr/d_wdata    load/store request, held until d_valid
//   d_rdata/d_valid/stall_mem   load data, completion pulse, stall
//   mem_addr/mem_wdata          memory address / write data (latched at grant)
//   mem_rd/mem_wr/mem_rdata     memory strobes and read data
//   busy                        arbiter is in any state other than IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              stall_if,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              stall_mem,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_last_data;   // 0: last grant was FETCH, 1: DATA
   logic              r_is_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_valid;
   logic              r_d_valid;

   logic w_f_pend;
   logic w_d_pend;
   logic w_grant_data;
   logic w_last;
   logic w_access;

   assign w_f_pend = if_req;
   assign w_d_pend = d_rd | d_wr;
   // Data wins when it is the only requester, or on a conflict when the
   // previous grant went to fetch (round-robin between the two ports).
   assign w_grant_data = w_d_pend & (~w_f_pend | ~r_last_data);
   assign w_last       = (r_cnt == 4'd0);
   assign w_access     = (r_state == S_FETCH) || (r_state == S_DATA);

   // Arbitration FSM: grant, access countdown, data capture and response.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_last_data <= 1'b0;
         r_is_wr     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_valid  <= 1'b0;
         r_d_valid   <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_f_pend || w_d_pend) begin
                  r_cnt       <= CNT_INIT;
                  r_last_data <= w_grant_data;
                  if (w_grant_data) begin
                     r_addr  <= d_addr;
                     r_wdata <= d_wdata;
                     // Both strobes high is treated as a store.
                     r_is_wr <= d_wr;
                     r_state <= S_DATA;
                  end else begin
                     r_addr  <= if_addr;
                     r_is_wr <= 1'b0;
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_FETCH, S_DATA: begin
               if (w_last) begin
                  if (r_state == S_FETCH) begin
                     r_if_rdata <= mem_rdata;
                     r_if_valid <= 1'b1;
                  end else begin
                     if (!r_is_wr) begin
                        r_d_rdata <= mem_rdata;
                     end else begin
                        r_d_rdata <= r_d_rdata;
                     end
                     r_d_valid <= 1'b1;
                  end
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign if_valid  = r_if_valid;
   assign d_valid   = r_d_valid;
   assign stall_if  = if_req & ~r_if_valid;
   assign stall_mem = (d_rd | d_wr) & ~r_d_valid;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = (r_state != S_IDLE);
   // Reads strobe for the whole access; a store writes only in its last cycle.
   assign mem_rd    = (r_state == S_FETCH) || ((r_state == S_DATA) && !r_is_wr);
   // Gated by RST_n so a reset landing on the final store cycle never writes.
   assign mem_wr    = RST_n & w_access & (r_state == S_DATA) & r_is_wr & w_last;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios for fetch, store, arbitration, combined rd/wr and reset
// during a store, followed by a randomized phase checked against a
// transaction-level reference model (grant order, access window timing,
// response cycle and memory contents).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int W = 2;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        stall_if;
   logic        d_rd;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_valid;
   logic        stall_mem;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
      .CLK(CLK), .RST_n(RST_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .stall_if(stall_if),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .stall_mem(stall_mem),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Background memory contents for locations never written.
   function automatic logic [15:0] bg(input logic [7:0] a);
      case (a)
         8'h10:   bg = 16'hA5C3;
         8'h50:   bg = 16'hBEEF;
         default: bg = {~a, a};
      endcase
   endfunction

   // Bench memory: 256 words indexed by the low address byte.
   bit [15:0] tb_mem [256];
   bit        tb_wr  [256];
   int        wr_pulses = 0;

   always @(posedge CLK) begin
      if (mem_wr === 1'b1) begin
         tb_mem[mem_addr[7:0]] <= mem_wdata;
         tb_wr[mem_addr[7:0]]  <= 1'b1;
         wr_pulses             <= wr_pulses + 1;
      end
   end

   assign mem_rdata = tb_wr[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]] : bg(mem_addr[7:0]);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_n = 1'b0; if_req = 1'b0; if_addr = 16'h0; d_rd = 1'b0; d_wr = 1'b0;
      d_addr = 16'h0; d_wdata = 16'h0;
      tick();
      tick();
      RST_n = 1'b1;
   endtask

   // Reference model state for the randomized phase.
   bit [15:0] mdl_mem [256];
   bit        mdl_wr  [256];
   int        free_at, g_start, kind, w0;
   bit        g_have, g_data, g_wr, last_data, acc, rsp, prev_ifv, prev_dv;
   logic [15:0] g_addr, g_wdata, g_exp;

   initial begin
      do_reset();
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_ifv", if_valid, 1'b0);
      check("rst_dv", d_valid, 1'b0);
      check("rst_ifrd", if_rdata, 16'h0);
      check("rst_drd", d_rdata, 16'h0);
      check("rst_maddr", mem_addr, 16'h0);
      check("rst_mwd", mem_wdata, 16'h0);
      check("rst_mrd", mem_rd, 1'b0);
      check("rst_mwr", mem_wr, 1'b0);
      tick();

      // Fetch alone; address changes mid-access must be ignored.
      if_req = 1'b1; if_addr = 16'h0010;
      for (int c = 0; c <= 4; c++) begin
         if (c == 1) if_addr = 16'h0020;
         if (c == 4) if_req = 1'b0;
         #1;
         check("f_mem_rd", mem_rd, (c == 1 || c == 2));
         check("f_valid", if_valid, (c == 3));
         check("f_stall", stall_if, (c <= 2));
         check("f_busy", busy, (c >= 1 && c <= 3));
         if (c == 1 || c == 2) check("f_addr", mem_addr, 16'h0010);
         if (c >= 3) check("f_data", if_rdata, 16'hA5C3);
         tick();
      end

      // Store alone: exactly one write pulse in the last access cycle.
      w0 = wr_pulses;
      d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
      for (int c = 0; c <= 4; c++) begin
         if (c == 4) d_wr = 1'b0;
         #1;
         check("s_mem_wr", mem_wr, (c == 2));
         check("s_mem_rd", mem_rd, 1'b0);
         check("s_valid", d_valid, (c == 3));
         check("s_stall", stall_mem, (c <= 2));
         if (c == 2) begin
            check("s_addr", mem_addr, 16'h0040);
            check("s_wdata", mem_wdata, 16'h1234);
         end
         tick();
      end
      check("s_pulses", wr_pulses - w0, 1);
      check("s_memval", tb_mem[8'h40], 16'h1234);

      // Conflicts after reset: data first, then alternating grants.
      do_reset();
      for (int c = 0; c <= 15; c++) begin
         if_req = 1'b1; if_addr = 16'h0010;
         d_rd = (c < 12); d_addr = (c < 4) ? 16'h0040 : 16'h0050;
         #1;
         check("c_ifv", if_valid, (c == 7 || c == 15));
         check("c_dv", d_valid, (c == 3 || c == 11));
         check("c_stall_if", stall_if, !(c == 7 || c == 15));
         if (c == 1 || c == 2) check("c_addr1", mem_addr, 16'h0040);
         if (c == 5 || c == 6) check("c_addr2", mem_addr, 16'h0010);
         if (c == 9 || c == 10) check("c_addr3", mem_addr, 16'h0050);
         if (c == 13 || c == 14) check("c_addr4", mem_addr, 16'h0010);
         if (c == 3) check("c_drd1", d_rdata, 16'h1234);
         if (c == 11) check("c_drd2", d_rdata, 16'hBEEF);
         if (c == 15) check("c_ifrd", if_rdata, 16'hA5C3);
         tick();
      end
      if_req = 1'b0; d_rd = 1'b0;
      tick();

      // d_rd and d_wr together behave as a store.
      d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0060; d_wdata = 16'h5A5A;
      for (int c = 0; c <= 4; c++) begin
         if (c == 4) begin d_rd = 1'b0; d_wr = 1'b0; end
         #1;
         check("b_mem_rd", mem_rd, 1'b0);
         check("b_mem_wr", mem_wr, (c == 2));
         check("b_valid", d_valid, (c == 3));
         if (c == 3) check("b_drd_held", d_rdata, 16'hBEEF);
         tick();
      end
      check("b_memval", tb_mem[8'h60], 16'h5A5A);

      // Reset during the final cycle of a store.
      w0 = wr_pulses;
      d_wr = 1'b1; d_addr = 16'h0070; d_wdata = 16'h7777;
      tick();
      tick();
      RST_n = 1'b0; d_wr = 1'b0;
      #1;
      check("r_mem_wr_gated", mem_wr, 1'b0);
      tick();
      RST_n = 1'b1;
      #1;
      check("r_busy", busy, 1'b0);
      check("r_dv", d_valid, 1'b0);
      check("r_maddr", mem_addr, 16'h0);
      check("r_mwd", mem_wdata, 16'h0);
      check("r_ifrd", if_rdata, 16'h0);
      check("r_drd", d_rdata, 16'h0);
      check("r_mrd", mem_rd, 1'b0);
      check("r_mwr", mem_wr, 1'b0);
      check("r_stall", stall_mem, 1'b0);
      tick();
      check("r_dv_late", d_valid, 1'b0);
      check("r_pulses", wr_pulses - w0, 0);

      // Randomized traffic against the transaction-level model.
      do_reset();
      free_at = 0; last_data = 1'b0; g_have = 1'b0; g_start = 0;
      prev_ifv = 1'b0; prev_dv = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (prev_ifv) if_req = 1'b0;
         if (prev_dv) begin d_rd = 1'b0; d_wr = 1'b0; end
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = {8'($urandom), 1'b1, 7'($urandom)};
         end
         if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
            kind = $urandom_range(0, 2);
            d_rd = (kind != 1); d_wr = (kind != 0);
            d_addr = {8'($urandom), 1'b1, 7'($urandom)}; d_wdata = 16'($urandom);
         end
         if (cyc >= free_at && (if_req || d_rd || d_wr)) begin
            g_have = 1'b1; g_start = cyc; free_at = cyc + W + 2;
            g_data = (d_rd || d_wr) && (!if_req || !last_data);
            last_data = g_data;
            if (g_data) begin
               g_addr = d_addr; g_wr = d_wr; g_wdata = d_wdata;
            end else begin
               g_addr = if_addr; g_wr = 1'b0; g_wdata = 16'h0;
            end
            g_exp = mdl_wr[g_addr[7:0]] ? mdl_mem[g_addr[7:0]] : bg(g_addr[7:0]);
         end
         #1;
         acc = g_have && cyc > g_start && cyc <= g_start + W;
         rsp = g_have && cyc == g_start + W + 1;
         check("x_mem_rd", mem_rd, acc && !g_wr);
         check("x_mem_wr", mem_wr, acc && g_wr && cyc == g_start + W);
         check("x_busy", busy, acc || rsp);
         check("x_ifv", if_valid, rsp && !g_data);
         check("x_dv", d_valid, rsp && g_data);
         check("x_stall_if", stall_if, if_req && !(rsp && !g_data));
         check("x_stall_mem", stall_mem, (d_rd || d_wr) && !(rsp && g_data));
         if (acc) check("x_addr", mem_addr, g_addr);
         if (acc && g_wr) check("x_wdata", mem_wdata, g_wdata);
         if (rsp && !g_data) check("x_ifrd", if_rdata, g_exp);
         if (rsp && g_data && !g_wr) check("x_drd", d_rdata, g_exp);
         if (acc && g_wr && cyc == g_start + W) begin
            mdl_mem[g_addr[7:0]] = g_wdata;
            mdl_wr[g_addr[7:0]]  = 1'b1;
         end
         prev_ifv = (if_valid === 1'b1);
         prev_dv  = (d_valid === 1'b1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage (read-only port) and the MEM stage (load/store port) of the 16-bit pipelined processor.
- Sequences each access over a fixed number of memory wait cycles.
- Returns data with a one-cycle valid pulse.
- Produces per-port stall signals that freeze the requesting stage until its access completes.
- Sits between the IF/MEM stages and the memory; the hazard unit ORs stall_if and stall_mem into the pipeline stall.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data width.
WAIT_CYCLES, 2, number of cycles each access holds the memory bus (legal range 1..15).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_n  input  1  reset, synchronous, active-low.
if_req  input  1  fetch request; held high with if_addr stable until if_valid.
if_addr  input  ADDR_W  fetch address (PC).
if_rdata  output  DATA_W  fetched instruction; registered, held until the next fetch completes.
if_valid  output  1  one-cycle pulse when if_rdata is updated.
stall_if  output  1  = if_req & ~if_valid.
d_rd  input  1  load request; held until d_valid.
d_wr  input  1  store request; held until d_valid.
d_addr  input  ADDR_W  load/store address.
d_wdata  input  DATA_W  store data.
d_rdata  output  DATA_W  load data; registered, held until the next load completes.
d_valid  output  1  one-cycle completion pulse (loads and stores).
stall_mem  output  1  = (d_rd | d_wr) & ~d_valid.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  DATA_W  memory write data.
mem_rd  output  1  memory read strobe.
mem_wr  output  1  memory write strobe.
mem_rdata  input  DATA_W  memory read data; valid combinationally in the last access cycle.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK; reset RST_n is synchronous and active-low.
- Reset values: state=IDLE, cnt=0, last_grant=FETCH. All outputs 0, including if_rdata, d_rdata and mem_addr.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE, arbitration and latching:
  - Pending requests: fetch = if_req; data = d_rd | d_wr.
  - Only one pending → grant it.
  - Both pending → grant the one not equal to last_grant. After reset, data therefore wins the first conflict.
  - On grant: latch address, write data and type (read/write); set cnt = WAIT_CYCLES-1; update last_grant; go to FETCH or DATA.
  - d_rd and d_wr both high → treated as a store.
- FETCH/DATA, memory access:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_rd is high in every cycle of a read access.
  - mem_wr is high only in the final cycle (cnt==0) of a store, so each store produces exactly one write pulse.
  - cnt decrements each cycle.
  - When cnt==0: a read captures mem_rdata into if_rdata or d_rdata; the FSM then goes to RESP.
- RESP, response:
  - The served port's valid is high for exactly this cycle; its stall drops, so the stage advances at the next edge.
  - No grant in RESP; next state is IDLE.
- Latency: a request seen in IDLE at cycle 0 produces valid in cycle WAIT_CYCLES+1. Occupancy is WAIT_CYCLES+2 cycles per access.
- Requester input changes during FETCH/DATA/RESP are ignored, because values are latched at grant.
- A request dropped before grant is never served.
- Outside the access states, mem_rd and mem_wr are 0.
- Reset mid-access:
  - Abandon the access; no valid pulse, no data capture.
  - mem_wr is gated combinationally by RST_n, so no write occurs in any cycle where RST_n=0.
- WAIT_CYCLES=1: the access state lasts one cycle; it is both first and last.

Test Plan:
- Fetch alone, WAIT_CYCLES=2, if_addr=0x0010, memory returns 0xA5C3 → mem_rd high cycles 1–2; if_valid high in cycle 3 with if_rdata=0xA5C3; stall_if high cycles 0–2; busy low again in cycle 4.
- Store alone, d_addr=0x0040, d_wdata=0x1234 → mem_wr high only in cycle 2 with mem_addr=0x0040 and mem_wdata=0x1234; d_valid in cycle 3; exactly one write pulse.
- Simultaneous if_req and d_rd right after reset → data served first (d_valid in cycle 3); fetch granted in cycle 4 and valid in cycle 7. Repeat the conflict: grants alternate.
- d_rd and d_wr both high → a store is performed and mem_rd stays low.
- RST_n low during the final cycle of a store → mem_wr=0 that cycle; next cycle state=IDLE; no d_valid; all outputs 0.
- if_addr changed mid-access from 0x0010 to 0x0020 → mem_addr stays 0x0010 for the whole access.
